alu_decode_stage: RTL and testbench
===================================

# alu_decode_stage

- Registered RV32I decode stage for the execute pipeline.
- Accepts one instruction word plus PC per cycle over a valid/ready handshake and emits a 4-bit ALU operation code, operand-select controls and a sign-extended immediate.
- Its outputs drive the ALU operation input and the operand muxes of the execute stage.
- Holds its output on back-pressure, drops it on flush, and flags unsupported encodings.

## Interface
- No parameters; XLEN fixed at 32.
- Reset is synchronous and active-high; one clock.
- clk  in  1  — single clock, rising edge.
- rst  in  1  — reset.
- flush  in  1  — kill the held or incoming instruction.
- in_valid  in  1  — instr/pc valid.
- in_ready  out  1  — stage can accept.
- instr  in  32  — instruction word.
- pc  in  32  — instruction address.
- out_valid  out  1  — decoded bundle valid.
- out_ready  in  1  — execute stage accepts the bundle.
- out_pc  out  32  — registered pc.
- out_alu_control  out  4  — ALU operation code.
- out_src_a  out  2  — operand A select: 00 rs1, 01 pc, 10 zero.
- out_src_b_imm  out  1  — operand B select: 1 selects out_imm, 0 selects rs2.
- out_imm  out  32  — decoded immediate.
- out_branch  out  1  — conditional branch.
- out_illegal  out  1  — unsupported encoding.

## Operation
- ALU codes:
  - ADD 0000, SLL 0001, SLT 0010, SLTU 0011
  - XOR 0100, SRL 0101, OR 0110, AND 0111
  - SUB 1000, SGE 1010, SGEU 1011, SRA 1101
  - All other codes are unused.
- OP (0110011):
  - funct7=0000000: code {0, funct3}.
  - funct7=0100000 with funct3 000 or 101: code {1, funct3}.
  - Any other funct7: illegal.
  - src_b=rs2.
- OP-IMM (0010011):
  - funct3 001 requires funct7=0000000, else illegal.
  - funct3 101: code {funct7[5], 101}; requires funct7 of 0000000 or 0100000, else illegal.
  - Other funct3: code {0, funct3}.
  - Immediate for funct3 001/101 is zero-extended instr[24:20]; otherwise sign-extended I-immediate.
  - src_b=imm.
- LOAD (0000011) and JALR (1100111): ADD, rs1 + I-immediate.
- STORE (0100011): ADD, rs1 + S-immediate.
- BRANCH (1100011):
  - out_branch=1, src_b=rs2, out_imm = B-immediate.
  - funct3 000/001 → SUB; 100 → SLT; 101 → SGE; 110 → SLTU; 111 → SGEU; 010/011 → illegal.
- LUI (0110111): ADD, src_a=zero, U-immediate.
- AUIPC (0010111): ADD, src_a=pc, U-immediate.
- JAL (1101111): ADD, src_a=pc, J-immediate.
- Any other opcode: illegal.
- Illegal bundle: code ADD, src_a=00, src_b_imm=0, imm=0, branch=0, out_illegal=1. It is still passed downstream with out_valid=1 so the trap logic sees it.
- Output register states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- in_ready = !out_valid | out_ready (combinational, no bubble).
- Load condition: in_valid & in_ready & !flush.
  - Register captures the decode and goes or stays FULL.
- FULL & out_ready & no load → EMPTY.
- FULL & !out_ready: all out_* held bit-stable.

## Timing
- Latency: 1 cycle from accepted instr to out_valid.
- Throughput: 1 instruction per cycle while out_ready=1.
- Reset (sampled at clk edge): out_valid=0, out_alu_control=0000, out_src_a=00, out_src_b_imm=0, out_imm=0, out_pc=0, out_branch=0, out_illegal=0.
  - in_ready=1 from the first cycle after reset.
  - rst asserted mid-stall discards the held bundle.
- flush:
  - Next cycle out_valid=0.
  - The same-cycle input is not captured, even though in_ready may read 1.
  - flush and out_ready together: flush wins; nothing new is loaded.
  - rst has priority over flush.
- Simultaneous handshake: FULL & out_ready & in_valid → new bundle replaces old in one edge; out_valid stays 1.
- Only valid/control flops need reset; data flops must still read as reset values when out_valid=0.

## Structure
- Shared package alu_pkg holds:
  - the ALU code localparams (ALU_ADD … ALU_SRA);
  - the opcode constants;
  - the src_a encoding constants.
- The ALU imports the same package.
- Sub-module imm_gen: purely combinational; takes instr and produces the I/S/B/U/J/shamt immediate selected by opcode/funct3.
- Main block = combinational decode + one output register + handshake logic.

## Test plan
- add x3,x1,x2 (instr 0x002081B3, in_valid=1, out_ready=1) → next cycle: out_valid=1, code 0000, src_a=00, src_b_imm=0, illegal=0.
- sub 0x402081B3 → 1000; srai x1,x1,3 (0x4030D093) → 1101, src_b_imm=1, imm=0x00000003.
- bge x1,x2,+8 (0x0020D463) → 1010, branch=1, imm=8; lui x5,0x12345 (0x123452B7) → ADD, src_a=10, imm=0x12345000.
- Back-pressure:
  - out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs stable.
  - Releasing out_ready → next instr appears one cycle later; no drop or duplicate.
- Flush:
  - FULL + flush → out_valid=0 next cycle.
  - flush with in_valid=1 → that instr is never emitted.
  - rst during a stall → all outputs at reset values.
- Illegal:
  - 0x0000007F → out_illegal=1, code 0000, imm 0.
  - 0x0020A463 (funct3 010 branch) → illegal.
  - slli with funct7=0100000 → illegal.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: constants shared by the RV32I decode stage and the ALU.
//   - ALU operation codes (4 bits, bit 3 selects the subtract/arithmetic variant)
//   - RV32I major opcodes handled by the decoder
//   - operand A select encoding
//   - output register state and decoded bundle type
package alu_pkg;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SGE  = 4'b1010;
  localparam logic [3:0] ALU_SGEU = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  // RV32I major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Operand A select
  localparam logic [1:0] SRC_A_RS1  = 2'b00;
  localparam logic [1:0] SRC_A_PC   = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  typedef struct packed {
    logic [3:0]  alu_control;
    logic [1:0]  src_a;
    logic        src_b_imm;
    logic [31:0] imm;
    logic        branch;
    logic        illegal;
  } decode_t;

endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational RV32I immediate generator.
//   instr_i  in  32  instruction word
//   imm_o    out 32  immediate selected by opcode/funct3 (I/S/B/U/J or
//                    zero-extended shift amount); zero for formats without one
module imm_gen
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o
);

  logic [31:0] i_imm;
  logic [31:0] s_imm;
  logic [31:0] b_imm;
  logic [31:0] u_imm;
  logic [31:0] j_imm;
  logic [31:0] shamt;

  assign i_imm = {{20{instr_i[31]}}, instr_i[31:20]};
  assign s_imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign b_imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                  instr_i[11:8], 1'b0};
  assign u_imm = {instr_i[31:12], 12'b0};
  assign j_imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                  instr_i[30:21], 1'b0};
  assign shamt = {27'b0, instr_i[24:20]};

  always_comb begin
    imm_o = '0;
    case (instr_i[6:0])
      OPC_OP_IMM: begin
        // Shifts carry a 5-bit unsigned shift amount, not a signed immediate
        if (instr_i[14:12] == 3'b001 || instr_i[14:12] == 3'b101) begin
          imm_o = shamt;
        end else begin
          imm_o = i_imm;
        end
      end
      OPC_LOAD, OPC_JALR: imm_o = i_imm;
      OPC_STORE:          imm_o = s_imm;
      OPC_BRANCH:         imm_o = b_imm;
      OPC_LUI, OPC_AUIPC: imm_o = u_imm;
      OPC_JAL:            imm_o = j_imm;
      default:            imm_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: registered RV32I decode stage feeding the execute ALU.
//   clk, rst         clock and synchronous active-high reset
//   flush            kill held bundle and refuse the same-cycle input
//   in_valid/ready   input handshake (instr, pc)
//   out_valid/ready  output handshake
//   out_pc           pc of the decoded instruction
//   out_alu_control  ALU operation code
//   out_src_a        operand A select (00 rs1, 01 pc, 10 zero)
//   out_src_b_imm    operand B select (1 imm, 0 rs2)
//   out_imm          decoded immediate
//   out_branch       conditional branch
//   out_illegal      unsupported encoding (still delivered with out_valid=1)
module alu_decode_stage
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [3:0]  out_alu_control,
  output logic [1:0]  out_src_a,
  output logic        out_src_b_imm,
  output logic [31:0] out_imm,
  output logic        out_branch,
  output logic        out_illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] gen_imm;

  logic [3:0]  dec_alu;
  logic [1:0]  dec_src_a;
  logic        dec_src_b;
  logic        dec_branch;
  logic        dec_illegal;
  decode_t     dec_bundle;

  out_state_e  state_q, state_d;
  decode_t     bundle_q, bundle_d;
  logic [31:0] pc_q, pc_d;

  logic        load;
  logic        hold;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  imm_gen u_imm_gen (
    .instr_i (instr),
    .imm_o   (gen_imm)
  );

  // Combinational decode of the incoming instruction
  always_comb begin
    dec_alu     = ALU_ADD;
    dec_src_a   = SRC_A_RS1;
    dec_src_b   = 1'b0;
    dec_branch  = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == 7'b0000000) begin
          dec_alu = {1'b0, funct3};
        end else if (funct7 == 7'b0100000 &&
                     (funct3 == 3'b000 || funct3 == 3'b101)) begin
          dec_alu = {1'b1, funct3};
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_src_b = 1'b1;
        case (funct3)
          3'b001: begin
            dec_alu = ALU_SLL;
            if (funct7 != 7'b0000000) dec_illegal = 1'b1;
          end
          3'b101: begin
            // funct7[5] distinguishes SRAI from SRLI
            dec_alu = {funct7[5], 3'b101};
            if (funct7 != 7'b0000000 && funct7 != 7'b0100000) dec_illegal = 1'b1;
          end
          default: dec_alu = {1'b0, funct3};
        endcase
      end
      OPC_LOAD, OPC_JALR, OPC_STORE: begin
        dec_src_b = 1'b1;
      end
      OPC_BRANCH: begin
        dec_branch = 1'b1;
        case (funct3)
          3'b000, 3'b001: dec_alu = ALU_SUB;
          3'b100:         dec_alu = ALU_SLT;
          3'b101:         dec_alu = ALU_SGE;
          3'b110:         dec_alu = ALU_SLTU;
          3'b111:         dec_alu = ALU_SGEU;
          default:        dec_illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec_src_a = SRC_A_ZERO;
        dec_src_b = 1'b1;
      end
      OPC_AUIPC, OPC_JAL: begin
        dec_src_a = SRC_A_PC;
        dec_src_b = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase

    // Illegal encodings travel as a neutral ADD bundle so the trap logic
    // downstream sees only the illegal flag.
    dec_bundle = '0;
    if (dec_illegal) begin
      dec_bundle.illegal = 1'b1;
    end else begin
      dec_bundle.alu_control = dec_alu;
      dec_bundle.src_a       = dec_src_a;
      dec_bundle.src_b_imm   = dec_src_b;
      dec_bundle.imm         = gen_imm;
      dec_bundle.branch      = dec_branch;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign load      = in_valid && in_ready && !flush;
  assign hold      = out_valid && !out_ready && !flush;

  // Data registers are cleared whenever the stage goes empty so that the
  // outputs always read as reset values while out_valid is low.
  always_comb begin
    state_d  = ST_EMPTY;
    bundle_d = '0;
    pc_d     = '0;
    if (load) begin
      state_d  = ST_FULL;
      bundle_d = dec_bundle;
      pc_d     = pc;
    end else if (hold) begin
      state_d  = state_q;
      bundle_d = bundle_q;
      pc_d     = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      bundle_q <= '0;
      pc_q     <= '0;
    end else begin
      state_q  <= state_d;
      bundle_q <= bundle_d;
      pc_q     <= pc_d;
    end
  end

  assign out_pc          = pc_q;
  assign out_alu_control = bundle_q.alu_control;
  assign out_src_a       = bundle_q.src_a;
  assign out_src_b_imm   = bundle_q.src_b_imm;
  assign out_imm         = bundle_q.imm;
  assign out_branch      = bundle_q.branch;
  assign out_illegal     = bundle_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
module tb_alu_decode_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [3:0]  out_alu_control;
  logic [1:0]  out_src_a;
  logic        out_src_b_imm;
  logic [31:0] out_imm;
  logic        out_branch;
  logic        out_illegal;

  int n_vec;
  int n_err;

  alu_decode_stage dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .instr           (instr),
    .pc              (pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_alu_control (out_alu_control),
    .out_src_a       (out_src_a),
    .out_src_b_imm   (out_src_b_imm),
    .out_imm         (out_imm),
    .out_branch      (out_branch),
    .out_illegal     (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] epc,
                         input logic [3:0] code, input logic [1:0] sa, input logic sb,
                         input logic [31:0] imm, input logic br, input logic ill);
    chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, v});
    chk({tag, ".pc"}, out_pc, epc);
    chk({tag, ".code"}, {28'b0, out_alu_control}, {28'b0, code});
    chk({tag, ".src_a"}, {30'b0, out_src_a}, {30'b0, sa});
    chk({tag, ".src_b_imm"}, {31'b0, out_src_b_imm}, {31'b0, sb});
    chk({tag, ".imm"}, out_imm, imm);
    chk({tag, ".branch"}, {31'b0, out_branch}, {31'b0, br});
    chk({tag, ".illegal"}, {31'b0, out_illegal}, {31'b0, ill});
    $display("txn %s: valid=%0b pc=%08h code=%04b src_a=%02b src_b_imm=%0b imm=%08h br=%0b ill=%0b",
             tag, out_valid, out_pc, out_alu_control, out_src_a, out_src_b_imm,
             out_imm, out_branch, out_illegal);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction with out_ready=1 and advance one edge
  task automatic send(input logic [31:0] i, input logic [31:0] p);
    in_valid  = 1'b1;
    instr     = i;
    pc        = p;
    out_ready = 1'b1;
    cyc();
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    instr     = '0;
    pc        = '0;
    out_ready = 1'b1;
    cyc();
    cyc();
    chk_out("reset", 0, 0, 4'b0000, 2'b00, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", {31'b0, in_ready}, 32'd1);

    // Back-to-back legal instructions (out_valid stays high across replacements)
    send(32'h002081B3, 32'h1000); chk_out("add",   1, 32'h1000, 4'b0000, 2'b00, 0, 32'h0, 0, 0);
    send(32'h402081B3, 32'h1004); chk_out("sub",   1, 32'h1004, 4'b1000, 2'b00, 0, 32'h0, 0, 0);
    send(32'h4030D093, 32'h1008); chk_out("srai",  1, 32'h1008, 4'b1101, 2'b00, 1, 32'h3, 0, 0);
    send(32'h0030D093, 32'h100C); chk_out("srli",  1, 32'h100C, 4'b0101, 2'b00, 1, 32'h3, 0, 0);
    send(32'h0020D463, 32'h1010); chk_out("bge",   1, 32'h1010, 4'b1010, 2'b00, 0, 32'h8, 1, 0);
    send(32'hFE000EE3, 32'h1014); chk_out("beq_m4",1, 32'h1014, 4'b1000, 2'b00, 0, 32'hFFFFFFFC, 1, 0);
    send(32'h0020E863, 32'h1018); chk_out("bltu",  1, 32'h1018, 4'b0011, 2'b00, 0, 32'h10, 1, 0);
    send(32'h123452B7, 32'h101C); chk_out("lui",   1, 32'h101C, 4'b0000, 2'b10, 1, 32'h12345000, 0, 0);
    send(32'h00001517, 32'h1020); chk_out("auipc", 1, 32'h1020, 4'b0000, 2'b01, 1, 32'h00001000, 0, 0);
    send(32'h008000EF, 32'h1024); chk_out("jal",   1, 32'h1024, 4'b0000, 2'b01, 1, 32'h8, 0, 0);
    send(32'h00408067, 32'h1028); chk_out("jalr",  1, 32'h1028, 4'b0000, 2'b00, 1, 32'h4, 0, 0);
    send(32'hFFF00093, 32'h102C); chk_out("addi_m1",1,32'h102C, 4'b0000, 2'b00, 1, 32'hFFFFFFFF, 0, 0);
    send(32'h0020A423, 32'h1030); chk_out("sw",    1, 32'h1030, 4'b0000, 2'b00, 1, 32'h8, 0, 0);
    send(32'hFFC0A183, 32'h1034); chk_out("lw",    1, 32'h1034, 4'b0000, 2'b00, 1, 32'hFFFFFFFC, 0, 0);

    // Illegal encodings
    send(32'h0000007F, 32'h1100); chk_out("ill_opc",   1, 32'h1100, 4'b0000, 2'b00, 0, 32'h0, 0, 1);
    send(32'h0020A463, 32'h1104); chk_out("ill_br010", 1, 32'h1104, 4'b0000, 2'b00, 0, 32'h0, 0, 1);
    send(32'h40309093, 32'h1108); chk_out("ill_slli",  1, 32'h1108, 4'b0000, 2'b00, 0, 32'h0, 0, 1);
    send(32'h402091B3, 32'h110C); chk_out("ill_op_f7", 1, 32'h110C, 4'b0000, 2'b00, 0, 32'h0, 0, 1);
    send(32'h022081B3, 32'h1110); chk_out("ill_mul",   1, 32'h1110, 4'b0000, 2'b00, 0, 32'h0, 0, 1);

    // Back-pressure: hold for 3 cycles, then release
    send(32'h002081B3, 32'h2000);
    in_valid  = 1'b1;
    instr     = 32'h402081B3;
    pc        = 32'h2004;
    out_ready = 1'b0;
    #1;
    chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk_out("bp_hold", 1, 32'h2000, 4'b0000, 2'b00, 0, 32'h0, 0, 0);
      chk("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    cyc();
    chk_out("bp_release", 1, 32'h2004, 4'b1000, 2'b00, 0, 32'h0, 0, 0);
    in_valid = 1'b0;
    cyc();
    chk_out("bp_drain", 0, 32'h0, 4'b0000, 2'b00, 0, 32'h0, 0, 0);

    // Flush with a valid input on the same cycle
    send(32'h002081B3, 32'h3000);
    flush    = 1'b1;
    instr    = 32'h402081B3;
    pc       = 32'h3004;
    #1;
    chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
    cyc();
    chk_out("flush", 0, 32'h0, 4'b0000, 2'b00, 0, 32'h0, 0, 0);
    flush    = 1'b0;
    in_valid = 1'b0;
    cyc();
    chk_out("flush_no_emit", 0, 32'h0, 4'b0000, 2'b00, 0, 32'h0, 0, 0);

    // Flush during a stall
    send(32'h002081B3, 32'h3100);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b1;
    cyc();
    chk_out("flush_stall", 0, 32'h0, 4'b0000, 2'b00, 0, 32'h0, 0, 0);
    flush = 1'b0;

    // Reset during a stall discards the held bundle
    send(32'h123452B7, 32'h4000);
    in_valid  = 1'b1;
    instr     = 32'h002081B3;
    pc        = 32'h4004;
    out_ready = 1'b0;
    cyc();
    chk_out("rst_stall_pre", 1, 32'h4000, 4'b0000, 2'b10, 1, 32'h12345000, 0, 0);
    rst = 1'b1;
    cyc();
    chk_out("rst_stall", 0, 32'h0, 4'b0000, 2'b00, 0, 32'h0, 0, 0);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk("rst_stall_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_stall_valid", {31'b0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
